bus_grant_arbiter: RTL and testbench

- Round-robin arbiter for the shared 32-source internal bus.
- Each source raises one Req bit.
- The arbiter grants exactly one source at a time as a registered one-hot Grant.
- It also drives the matching 5-bit source Code to the bus multiplexer select.
- It enforces a release handshake, an optional hold timeout, and one turnaround cycle between owners.

---
 rtl/bus_grant_arbiter_pkg.sv | 14 +
 rtl/bus_grant_arbiter_rr_pick.sv | 30 +++
 rtl/bus_grant_arbiter.sv | 104 ++++++++++
 tb/tb_bus_grant_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_grant_arbiter_pkg.sv
// Shared definitions for the 32-source round-robin bus arbiter:
// requester count, code width and FSM state encoding.
package bus_grant_arbiter_pkg;

    localparam int N      = 32;
    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin winner search: rotate requests so Ptr sits at
// bit 0, find the lowest set bit, then undo the rotation modulo 32.
module rr_pick_32
    import bus_grant_arbiter_pkg::*;
(
    input  logic [N-1:0]      Req,
    input  logic [CODE_W-1:0] Ptr,
    output logic              Any,
    output logic [CODE_W-1:0] W
);

    logic [2*N-1:0]    doubled;
    logic [N-1:0]      rotated;
    logic [CODE_W-1:0] offset;

    always_comb begin
        doubled = {Req, Req} >> Ptr;
        rotated = doubled[N-1:0];
        offset  = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = CODE_W'(i);
            end
        end
        Any = |Req;
        W   = offset + Ptr;
    end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant with release handshake,
// optional hold timeout and a single turnaround cycle between owners.
module bus_grant_arbiter
    import bus_grant_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [N-1:0]      Req,
    input  logic              Release,
    output logic [N-1:0]      Grant,
    output logic [CODE_W-1:0] Code,
    output logic              Valid,
    output logic              Timeout
);

    localparam int HOLD_BITS = $clog2(MAX_HOLD + 1);
    localparam int HOLD_W    = (HOLD_BITS > 5) ? HOLD_BITS : 5;

    arb_state_t        state, nextState;
    logic [CODE_W-1:0] ptr, nextPtr;
    logic [HOLD_W-1:0] holdCount, nextHold;
    logic [N-1:0]      nextGrant;
    logic [CODE_W-1:0] nextCode;
    logic              nextValid, nextTimeout;

    logic              pickAny;
    logic [CODE_W-1:0] pickW;
    logic              releaseHit, withdrawHit, timeoutHit;

    rr_pick_32 u_pick (
        .Req (Req),
        .Ptr (ptr),
        .Any (pickAny),
        .W   (pickW)
    );

    always_comb begin
        releaseHit  = Release;
        withdrawHit = !Req[Code];
        timeoutHit  = (MAX_HOLD != 0) && (holdCount == HOLD_W'(MAX_HOLD - 1));

        nextState   = state;
        nextPtr     = ptr;
        nextHold    = holdCount;
        nextGrant   = '0;
        nextCode    = '0;
        nextValid   = 1'b0;
        nextTimeout = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pickAny) begin
                    nextGrant = {{(N-1){1'b0}}, 1'b1} << pickW;
                    nextCode  = pickW;
                    nextValid = 1'b1;
                    nextPtr   = pickW + CODE_W'(1);
                    nextHold  = '0;
                    nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (releaseHit || withdrawHit || timeoutHit) begin
                    // Timeout is reported only when it is the sole reason for leaving.
                    nextTimeout = timeoutHit && !releaseHit && !withdrawHit;
                    nextState   = ST_TURN;
                end else begin
                    nextGrant = Grant;
                    nextCode  = Code;
                    nextValid = 1'b1;
                end
                nextHold = (holdCount == '1) ? holdCount : holdCount + HOLD_W'(1);
            end
            ST_TURN: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            holdCount <= '0;
            Grant     <= '0;
            Code      <= '0;
            Valid     <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            state     <= nextState;
            ptr       <= nextPtr;
            holdCount <= nextHold;
            Grant     <= nextGrant;
            Code      <= nextCode;
            Valid     <= nextValid;
            Timeout   <= nextTimeout;
        end
    end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scoreboard bench for bus_grant_arbiter: stimulus queues expected grants,
// a negedge monitor checks each grant's code, length, gap and timeout.
module tb_bus_grant_arbiter;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Req;
    logic        Release;
    logic [31:0] Grant;
    logic [4:0]  Code;
    logic        Valid;
    logic        Timeout;

    int vectors     = 0;
    int miscompares = 0;
    bit monitorOn   = 1'b0;

    typedef struct {
        int code;
        int len;
        bit timeout;
        int gap;
    } expect_t;

    expect_t sbQueue[$];

    bus_grant_arbiter #(.MAX_HOLD(16)) dut (
        .clock   (clock),
        .clear   (clear),
        .Req     (Req),
        .Release (Release),
        .Grant   (Grant),
        .Code    (Code),
        .Valid   (Valid),
        .Timeout (Timeout)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [31:0] req, input logic rel, input logic clr);
        Req     = req;
        Release = rel;
        clear   = clr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect(input int code, input int len, input bit to, input int gap);
        expect_t e;
        e.code    = code;
        e.len     = len;
        e.timeout = to;
        e.gap     = gap;
        sbQueue.push_back(e);
    endtask

    task automatic waitValid();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (Valid === 1'b1) seen = 1'b1;
        end
        checkOutput("waitValid", {31'd0, seen}, 32'd1);
    endtask

    task automatic waitFall();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (Valid === 1'b0) seen = 1'b1;
        end
        checkOutput("waitFall", {31'd0, seen}, 32'd1);
    endtask

    task automatic pulseClear();
        applyStimulus(32'h0, 1'b0, 1'b1);
        @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: tracks Valid edges, pops one expected grant per rising edge.
    expect_t cur;
    bit      prevValid = 1'b0;
    int      curLen    = 0;
    int      gapCnt    = 0;

    always @(negedge clock) begin
        if (monitorOn) begin
            checkOutput("valid_eq_or_grant", {31'd0, Valid}, {31'd0, |Grant});
            checkOutput("grant_onehot0", {31'd0, $onehot0(Grant)}, 32'd1);
            if (Valid && !prevValid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_grant_code", {27'd0, Code}, 32'hFFFF_FFFF);
                    cur.code = -1; cur.len = -1; cur.timeout = 1'b0; cur.gap = -1;
                end else begin
                    cur = sbQueue.pop_front();
                    checkOutput("grant_code", {27'd0, Code}, cur.code);
                    checkOutput("grant_vector", Grant, 32'd1 << cur.code);
                    if (cur.gap >= 0) checkOutput("grant_gap", gapCnt, cur.gap);
                end
                curLen = 1;
            end else if (Valid && prevValid) begin
                curLen++;
                checkOutput("code_stable", {27'd0, Code}, cur.code);
            end else if (!Valid && prevValid) begin
                if (cur.len >= 0) checkOutput("hold_length", curLen, cur.len);
                checkOutput("timeout_at_release", {31'd0, Timeout}, {31'd0, cur.timeout});
                gapCnt = 1;
            end else begin
                gapCnt++;
                checkOutput("timeout_idle", {31'd0, Timeout}, 32'd0);
            end
            if (Valid) checkOutput("timeout_while_valid", {31'd0, Timeout}, 32'd0);
            prevValid = Valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired: got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset for two cycles and check the cleared outputs.
        applyStimulus(32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);
        checkOutput("reset_grant", Grant, 32'h0);
        checkOutput("reset_code", {27'd0, Code}, 32'h0);
        checkOutput("reset_valid", {31'd0, Valid}, 32'h0);
        checkOutput("reset_timeout", {31'd0, Timeout}, 32'h0);
        monitorOn = 1'b1;

        // Single request, one-cycle grant, release.
        pushExpect(4, 1, 1'b0, -1);
        applyStimulus(32'h0000_0010, 1'b0, 1'b0);
        waitValid();
        applyStimulus(32'h0, 1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);
        checkOutput("t1_turn_valid", {31'd0, Valid}, 32'h0);
        @(negedge clock);
        checkOutput("t1_idle_valid", {31'd0, Valid}, 32'h0);

        // Round robin between sources 0 and 31.
        pulseClear();
        pushExpect(0, 1, 1'b0, -1);
        pushExpect(31, 1, 1'b0, 2);
        pushExpect(0, 1, 1'b0, 2);
        pushExpect(31, 1, 1'b0, 2);
        applyStimulus(32'h8000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            waitValid();
            applyStimulus((i == 3) ? 32'h0 : 32'h8000_0001, 1'b1, 1'b0);
            @(negedge clock);
            applyStimulus((i == 3) ? 32'h0 : 32'h8000_0001, 1'b0, 1'b0);
        end

        // All 32 requesting: codes 0..31 then 0.
        pulseClear();
        for (int i = 0; i < 33; i++) pushExpect(i % 32, 1, 1'b0, (i == 0) ? -1 : 2);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 33; i++) begin
            waitValid();
            if (i == 32) applyStimulus(32'h0, 1'b1, 1'b0);
        end
        @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);

        // Hold timeout after 16 cycles, then regrant of source 8.
        pulseClear();
        pushExpect(8, 16, 1'b1, -1);
        pushExpect(8, 1, 1'b0, 2);
        applyStimulus(32'h0000_0100, 1'b0, 1'b0);
        waitValid();
        waitFall();
        checkOutput("t4_timeout_pulse", {31'd0, Timeout}, 32'd1);
        waitValid();
        applyStimulus(32'h0, 1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);

        // Owner withdraws: no timeout.
        pulseClear();
        pushExpect(3, 2, 1'b0, -1);
        applyStimulus(32'h0000_0008, 1'b0, 1'b0);
        waitValid();
        @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("t5_withdraw_valid", {31'd0, Valid}, 32'h0);

        // Clear mid-grant resets Ptr: source 5 again rather than 30.
        pushExpect(5, 1, 1'b0, -1);
        pushExpect(5, 1, 1'b0, 1);
        applyStimulus(32'h4000_0020, 1'b0, 1'b0);
        waitValid();
        applyStimulus(32'h4000_0020, 1'b1, 1'b1);
        @(negedge clock);
        applyStimulus(32'h4000_0020, 1'b0, 1'b0);
        checkOutput("t5_clear_grant", Grant, 32'h0);
        checkOutput("t5_clear_code", {27'd0, Code}, 32'h0);
        checkOutput("t5_clear_valid", {31'd0, Valid}, 32'h0);
        waitValid();
        applyStimulus(32'h0, 1'b1, 1'b0);
        @(negedge clock);
        applyStimulus(32'h0, 1'b0, 1'b0);

        repeat (5) @(negedge clock);
        checkOutput("scoreboard_empty", sbQueue.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
